// File: rtl/player_sprite_renderer.sv
// Player sprite renderer: per-frame position latch, hit/blink FSM and 1-cycle pixel pipeline.
// Define PLAYER_SPRITE_MASK_EN to shape the sprite with a bitmap ROM instead of a solid box.
module player_sprite_renderer #(
  parameter logic [9:0]  MONITOR_WIDTH = 10'd640,
  parameter logic [9:0]  PLAYER_WIDTH  = 10'd24,
  parameter logic [9:0]  PLAYER_HEIGHT = 10'd16,
  parameter logic [9:0]  PLAYER_Y      = 10'd440,
  parameter logic [7:0]  BLINK_FRAMES  = 8'd60,
  parameter logic [3:0]  BLINK_PERIOD  = 4'd4,
  parameter logic [11:0] PLAYER_COLOR  = 12'hFFF
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [9:0]  i_Player_Position,
  input  logic        i_fTick,
  input  logic        i_Hit,
  input  logic [9:0]  i_Pixel_X,
  input  logic [9:0]  i_Pixel_Y,
  input  logic        i_Video_On,
  output logic        o_Pixel_On,
  output logic [11:0] o_Color,
  output logic        o_Invincible
);

  localparam logic StIdle  = 1'b0;
  localparam logic StBlink = 1'b1;

  localparam logic [9:0] MaxPos    = MONITOR_WIDTH - PLAYER_WIDTH;
  localparam logic [9:0] CenterPos = MaxPos >> 1;

  logic       state_q, state_d;
  logic [9:0] pos_q, pos_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] phase_q, phase_d;
  logic       hide_q, hide_d;
  logic       pixel_on_q, pixel_on_d;
  logic       in_x, in_y, mask;

  // Position is only sampled at frame start so the sprite never tears.
  always_comb begin
    pos_d = pos_q;
    if (i_fTick) begin
      pos_d = (i_Player_Position > MaxPos) ? MaxPos : i_Player_Position;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    hide_d      = hide_q;
    if (state_q == StIdle) begin
      if (i_Hit) begin
        state_d     = StBlink;
        frame_cnt_d = BLINK_FRAMES;
        phase_d     = 4'd0;
        hide_d      = 1'b0;
      end
    end else if (i_fTick) begin
      if (frame_cnt_q == 8'd1) begin
        state_d     = StIdle;
        frame_cnt_d = 8'd0;
        phase_d     = 4'd0;
        hide_d      = 1'b0;
      end else begin
        frame_cnt_d = frame_cnt_q - 8'd1;
        if (phase_q == BLINK_PERIOD - 4'd1) begin
          phase_d = 4'd0;
          hide_d  = ~hide_q;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
    end
  end

  // 11-bit compares keep pos_q + width from wrapping near the right edge.
  always_comb begin
    in_x = ({1'b0, i_Pixel_X} >= {1'b0, pos_q}) &&
           ({1'b0, i_Pixel_X} < ({1'b0, pos_q} + {1'b0, PLAYER_WIDTH}));
    in_y = ({1'b0, i_Pixel_Y} >= {1'b0, PLAYER_Y}) &&
           ({1'b0, i_Pixel_Y} < ({1'b0, PLAYER_Y} + {1'b0, PLAYER_HEIGHT}));
  end

`ifdef PLAYER_SPRITE_MASK_EN
  logic [4:0]  col;
  logic [3:0]  row;
  logic [4:0]  bit_idx;
  logic [23:0] row_bits;

  assign col     = 5'(i_Pixel_X - pos_q);
  assign row     = 4'(i_Pixel_Y - PLAYER_Y);
  assign bit_idx = 5'(PLAYER_WIDTH - 10'd1) - col;

  always_comb begin
    row_bits = 24'h000000;
    case (row)
      4'd0:  row_bits = 24'h001800;
      4'd1:  row_bits = 24'h003C00;
      4'd2:  row_bits = 24'h003C00;
      4'd3:  row_bits = 24'h007E00;
      4'd4:  row_bits = 24'h007E00;
      4'd5:  row_bits = 24'h00FF00;
      4'd6:  row_bits = 24'h01FF80;
      4'd7:  row_bits = 24'h03FFC0;
      4'd8:  row_bits = 24'h07FFE0;
      4'd9:  row_bits = 24'h0FFFF0;
      4'd10: row_bits = 24'h1FFFF8;
      4'd11: row_bits = 24'h3FFFFC;
      4'd12: row_bits = 24'h7FFFFE;
      4'd13: row_bits = 24'hFFFFFF;
      4'd14: row_bits = 24'hFFFFFF;
      default: row_bits = 24'hE7E7E7;
    endcase
  end

  assign mask = row_bits[bit_idx];
`else
  assign mask = 1'b1;
`endif

  assign pixel_on_d = i_Video_On & in_x & in_y & mask & ~hide_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= StIdle;
      pos_q       <= CenterPos;
      frame_cnt_q <= 8'd0;
      phase_q     <= 4'd0;
      hide_q      <= 1'b0;
      pixel_on_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      hide_q      <= hide_d;
      pixel_on_q  <= pixel_on_d;
    end
  end

  assign o_Pixel_On   = pixel_on_q;
  assign o_Color      = pixel_on_q ? PLAYER_COLOR : 12'h000;
  assign o_Invincible = (state_q == StBlink);

endmodule
